// File: rtl/pong_pkg.sv
// pong_pkg: shared screen geometry, paddle faces and game FSM states
package pong_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PADDLE_SIZE = 40;
  localparam int FACE_L = 16;
  localparam int FACE_R = 625;
  localparam int CENTRE_X = 318;
  localparam int CENTRE_Y = 238;
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SERVE_DELAY = 3'd1,
    PLAY        = 3'd2,
    POINT       = 3'd3,
    GAMEOVER    = 3'd4
  } state_e;
endpackage

// File: rtl/pong_ball_step.sv
// pong_ball_step: one-frame ball motion with wall bounce, paddle hits and misses
module pong_ball_step
  import pong_pkg::*;
#(
  parameter int SPEED_X = 2,
  parameter int SPEED_Y = 1,
  parameter int BALL_SIZE = 4
) (
  input  logic [9:0] x_i,
  input  logic [8:0] y_i,
  input  logic       dx_i,
  input  logic       dy_i,
  input  logic [8:0] pos_l_i,
  input  logic [8:0] pos_r_i,
  output logic [9:0] x_o,
  output logic [8:0] y_o,
  output logic       dx_o,
  output logic       dy_o,
  output logic       hit_o,
  output logic       miss_l_o,
  output logic       miss_r_o
);
  localparam logic signed [10:0] SX = 11'(SPEED_X);
  localparam logic signed [10:0] SY = 11'(SPEED_Y);
  localparam logic signed [10:0] BS = 11'(BALL_SIZE);
  localparam logic signed [10:0] HALF = 11'(PADDLE_SIZE / 2);
  localparam logic signed [10:0] W = 11'(SCREEN_W);
  localparam logic signed [10:0] H = 11'(SCREEN_H);
  localparam logic signed [10:0] FL = 11'(FACE_L);
  localparam logic signed [10:0] FR = 11'(FACE_R);
  logic signed [10:0] x, y, ny, pl, pr;
  logic bot, top, cross_l, cross_r, hit_l, hit_r;
  assign x = $signed({1'b0, x_i});
  assign y = $signed({2'b0, y_i});
  assign pl = $signed({2'b0, pos_l_i});
  assign pr = $signed({2'b0, pos_r_i});
  assign bot = y + BS + SY > H;
  assign top = y < SY;
  assign ny = dy_i ? (bot ? H - BS : y + SY) : (top ? 11'sd0 : y - SY);
  assign dy_o = dy_i ? !bot : top;
  assign y_o = ny[8:0];
  assign cross_l = !dx_i && x >= FL && x - SX < FL;
  assign cross_r = dx_i && x + BS <= FR && x + BS + SX > FR;
  assign hit_l = cross_l && ny + BS > pl - HALF && ny < pl + HALF;
  assign hit_r = cross_r && ny + BS > pr - HALF && ny < pr + HALF;
  assign hit_o = hit_l | hit_r;
  assign miss_l_o = !dx_i && !hit_l && x < SX;
  assign miss_r_o = dx_i && !hit_r && x + BS + SX > W;
  assign x_o = 10'(hit_l ? FL : hit_r ? FR - BS : dx_i ? x + SX : x - SX);
  assign dx_o = hit_l ? 1'b1 : hit_r ? 1'b0 : dx_i;
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: serve/play/point/game-over sequencer stepping the ball once per frame
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int WIN_SCORE = 9,
  parameter int SPEED_X = 2,
  parameter int SPEED_Y = 1,
  parameter int BALL_SIZE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic [8:0] pos_l,
  input  logic [8:0] pos_r,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [2:0] state,
  output logic       ball_hit,
  output logic       game_over
);
  state_e state_q;
  logic [7:0] cnt_q;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic dx_q, dx_d, dy_q, dy_d, serve_dy_q, serve_q, hit_q, hit_d, go_q, miss_l, miss_r, win;
  logic [3:0] sl_q, sr_q, sc_d;
  logic serve_edge, last_serve, last_point;
  assign serve_edge = serve & ~serve_q;
  assign last_serve = cnt_q == 8'(SERVE_FRAMES - 1);
  assign last_point = cnt_q == 8'(POINT_FRAMES - 1);
  assign sc_d = (miss_l ? sr_q : sl_q) + 4'd1;
  assign win = sc_d == 4'(WIN_SCORE);
  assign ball_x = x_q;
  assign ball_y = y_q;
  assign score_l = sl_q;
  assign score_r = sr_q;
  assign state = state_q;
  assign ball_hit = hit_q;
  assign game_over = go_q;
  pong_ball_step #(.SPEED_X(SPEED_X), .SPEED_Y(SPEED_Y), .BALL_SIZE(BALL_SIZE)) u_step (
    .x_i(x_q), .y_i(y_q), .dx_i(dx_q), .dy_i(dy_q), .pos_l_i(pos_l), .pos_r_i(pos_r),
    .x_o(x_d), .y_o(y_d), .dx_o(dx_d), .dy_o(dy_d), .hit_o(hit_d),
    .miss_l_o(miss_l), .miss_r_o(miss_r)
  );
  // game FSM: serve sequencing, per-frame ball update, scoring; a serve edge beats a same-cycle tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      x_q <= 10'(CENTRE_X);
      y_q <= 9'(CENTRE_Y);
      dx_q <= 1'b1;
      dy_q <= 1'b1;
      serve_dy_q <= 1'b1;
      serve_q <= 1'b0;
      sl_q <= '0;
      sr_q <= '0;
      hit_q <= 1'b0;
      go_q <= 1'b0;
    end else begin
      serve_q <= serve;
      hit_q <= 1'b0;
      case (state_q)
        IDLE: if (serve_edge) begin
          state_q <= SERVE_DELAY;
          cnt_q <= '0;
        end
        SERVE_DELAY: if (frame_tick) begin
          cnt_q <= last_serve ? '0 : cnt_q + 8'd1;
          if (last_serve) state_q <= PLAY;
        end
        PLAY: if (frame_tick) begin
          if (miss_l | miss_r) begin
            if (miss_r) sl_q <= sc_d;
            else sr_q <= sc_d;
            state_q <= win ? GAMEOVER : POINT;
            go_q <= win;
            cnt_q <= '0;
            x_q <= 10'(CENTRE_X);
            y_q <= 9'(CENTRE_Y);
            dx_q <= miss_r;
            dy_q <= ~serve_dy_q;
            serve_dy_q <= ~serve_dy_q;
          end else begin
            x_q <= x_d;
            y_q <= y_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
            hit_q <= hit_d;
          end
        end
        POINT: if (frame_tick) begin
          cnt_q <= last_point ? '0 : cnt_q + 8'd1;
          if (last_point) state_q <= SERVE_DELAY;
        end
        GAMEOVER: if (serve_edge) begin
          state_q <= SERVE_DELAY;
          cnt_q <= '0;
          sl_q <= '0;
          sr_q <= '0;
          x_q <= 10'(CENTRE_X);
          y_q <= 9'(CENTRE_Y);
          dx_q <= 1'b1;
          dy_q <= 1'b1;
          serve_dy_q <= 1'b1;
          go_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed scenarios for serve, wall bounce, paddle hit/miss, scoring and reset
module tb_pong_game_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_tick = 1'b0;
  logic serve = 1'b0;
  logic [8:0] pos_l = 9'd240;
  logic [8:0] pos_r = 9'd240;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [3:0] score_l, score_r;
  logic [2:0] state;
  logic ball_hit, game_over;
  int checks = 0;
  int failures = 0;
  int hits = 0;
  int n, mx;
  pong_game_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .serve(serve),
    .pos_l(pos_l), .pos_r(pos_r), .ball_x(ball_x), .ball_y(ball_y),
    .score_l(score_l), .score_r(score_r), .state(state),
    .ball_hit(ball_hit), .game_over(game_over)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    if (ball_hit) hits++;
  endtask
  task automatic play_tick(input bit track_r);
    pos_l = 9'(ball_y + 9'd2);
    pos_r = track_r ? 9'(ball_y + 9'd2) : (ball_y < 9'd240 ? 9'd460 : 9'd20);
    tick();
  endtask
  task automatic test_reset();
    #1 rst = 1'b1;
    #12;
    checks++;
    if ({ball_x, ball_y, score_l, score_r, state, ball_hit, game_over} !== {10'd318, 9'd238, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: got x=%0d y=%0d sl=%0d sr=%0d st=%0d hit=%0d go=%0d, want 318 238 0 0 0 0 0", ball_x, ball_y, score_l, score_r, state, ball_hit, game_over);
    end
    @(negedge clk) rst = 1'b0;
    repeat (100) tick();
    checks++;
    if ({ball_x, ball_y, score_l, score_r, state} !== {10'd318, 9'd238, 4'd0, 4'd0, 3'd0}) begin
      failures++;
      $display("FAIL idle_ticks: got x=%0d y=%0d sl=%0d sr=%0d st=%0d, want 318 238 0 0 0", ball_x, ball_y, score_l, score_r, state);
    end
    checks++;
    if (hits !== 0) begin
      failures++;
      $display("FAIL idle_no_hit: got hits=%0d, want 0", hits);
    end
  endtask
  task automatic test_serve();
    @(negedge clk) serve = 1'b1;
    @(negedge clk) serve = 1'b0;
    checks++;
    if (state !== 3'd1) begin
      failures++;
      $display("FAIL serve_enter: got st=%0d, want 1", state);
    end
    repeat (59) tick();
    checks++;
    if ({state, ball_x, ball_y} !== {3'd1, 10'd318, 9'd238}) begin
      failures++;
      $display("FAIL serve_59: got st=%0d x=%0d y=%0d, want 1 318 238", state, ball_x, ball_y);
    end
    tick();
    checks++;
    if ({state, ball_x, ball_y} !== {3'd2, 10'd318, 9'd238}) begin
      failures++;
      $display("FAIL serve_60: got st=%0d x=%0d y=%0d, want 2 318 238", state, ball_x, ball_y);
    end
    tick();
    checks++;
    if ({state, ball_x, ball_y} !== {3'd2, 10'd320, 9'd239}) begin
      failures++;
      $display("FAIL first_move: got st=%0d x=%0d y=%0d, want 2 320 239", state, ball_x, ball_y);
    end
  endtask
  task automatic test_right_hit();
    n = 0;
    while (ball_x != 10'd620 && n < 400) begin
      play_tick(1'b1);
      n++;
    end
    checks++;
    if (ball_x !== 10'd620 || ball_y !== 9'd389 || n !== 150 || hits !== 0) begin
      failures++;
      $display("FAIL approach_right: got x=%0d y=%0d ticks=%0d hits=%0d, want 620 389 150 0", ball_x, ball_y, n, hits);
    end
    play_tick(1'b1);
    checks++;
    if ({ball_x, ball_y, ball_hit} !== {10'd621, 9'd390, 1'b1}) begin
      failures++;
      $display("FAIL right_hit: got x=%0d y=%0d hit=%0d, want 621 390 1", ball_x, ball_y, ball_hit);
    end
    @(negedge clk);
    checks++;
    if (ball_hit !== 1'b0) begin
      failures++;
      $display("FAIL hit_pulse_width: got hit=%0d one cycle later, want 0", ball_hit);
    end
    play_tick(1'b1);
    checks++;
    if ({ball_x, ball_y} !== {10'd619, 9'd391}) begin
      failures++;
      $display("FAIL after_hit_left: got x=%0d y=%0d, want 619 391", ball_x, ball_y);
    end
  endtask
  task automatic test_bottom_wall();
    n = 0;
    while (ball_y != 9'd476 && n < 200) begin
      play_tick(1'b0);
      n++;
    end
    checks++;
    if (ball_x !== 10'd449 || ball_y !== 9'd476 || n !== 85) begin
      failures++;
      $display("FAIL reach_bottom: got x=%0d y=%0d ticks=%0d, want 449 476 85", ball_x, ball_y, n);
    end
    play_tick(1'b0);
    checks++;
    if ({ball_x, ball_y} !== {10'd447, 9'd476}) begin
      failures++;
      $display("FAIL bottom_clamp: got x=%0d y=%0d, want 447 476", ball_x, ball_y);
    end
    play_tick(1'b0);
    checks++;
    if ({ball_x, ball_y} !== {10'd445, 9'd475}) begin
      failures++;
      $display("FAIL bottom_flip: got x=%0d y=%0d, want 445 475", ball_x, ball_y);
    end
  endtask
  task automatic test_right_miss();
    n = 0;
    mx = 0;
    while (state == 3'd2 && n < 2000) begin
      if (int'(ball_x) > mx) mx = int'(ball_x);
      play_tick(1'b0);
      n++;
    end
    checks++;
    if ({score_l, score_r, state, ball_x, ball_y} !== {4'd1, 4'd0, 3'd3, 10'd318, 9'd238}) begin
      failures++;
      $display("FAIL right_miss: got sl=%0d sr=%0d st=%0d x=%0d y=%0d, want 1 0 3 318 238", score_l, score_r, state, ball_x, ball_y);
    end
    checks++;
    if (mx !== 636 || hits !== 2) begin
      failures++;
      $display("FAIL miss_path: got max_x=%0d hits=%0d, want 636 2", mx, hits);
    end
    repeat (29) tick();
    checks++;
    if (state !== 3'd3) begin
      failures++;
      $display("FAIL point_29: got st=%0d, want 3", state);
    end
    tick();
    checks++;
    if ({state, ball_x, ball_y} !== {3'd1, 10'd318, 9'd238}) begin
      failures++;
      $display("FAIL point_30: got st=%0d x=%0d y=%0d, want 1 318 238", state, ball_x, ball_y);
    end
    repeat (60) tick();
    tick();
    checks++;
    if ({state, ball_x, ball_y} !== {3'd2, 10'd320, 9'd237}) begin
      failures++;
      $display("FAIL reserve_dir: got st=%0d x=%0d y=%0d, want 2 320 237", state, ball_x, ball_y);
    end
  endtask
  task automatic test_gameover();
    n = 0;
    while (state != 3'd4 && n < 20000) begin
      play_tick(1'b0);
      n++;
    end
    checks++;
    if ({score_l, score_r, state, game_over} !== {4'd9, 4'd0, 3'd4, 1'b1}) begin
      failures++;
      $display("FAIL left_wins: got sl=%0d sr=%0d st=%0d go=%0d, want 9 0 4 1", score_l, score_r, state, game_over);
    end
    repeat (5) tick();
    checks++;
    if ({score_l, state, game_over} !== {4'd9, 3'd4, 1'b1}) begin
      failures++;
      $display("FAIL gameover_hold: got sl=%0d st=%0d go=%0d, want 9 4 1", score_l, state, game_over);
    end
    @(negedge clk) begin
      serve = 1'b1;
      frame_tick = 1'b1;
    end
    @(negedge clk) begin
      serve = 1'b0;
      frame_tick = 1'b0;
    end
    checks++;
    if ({score_l, score_r, state, game_over, ball_x, ball_y} !== {4'd0, 4'd0, 3'd1, 1'b0, 10'd318, 9'd238}) begin
      failures++;
      $display("FAIL restart: got sl=%0d sr=%0d st=%0d go=%0d x=%0d y=%0d, want 0 0 1 0 318 238", score_l, score_r, state, game_over, ball_x, ball_y);
    end
    repeat (59) tick();
    checks++;
    if (state !== 3'd1) begin
      failures++;
      $display("FAIL restart_59: got st=%0d, want 1", state);
    end
    tick();
    tick();
    checks++;
    if ({state, ball_x, ball_y} !== {3'd2, 10'd320, 9'd239}) begin
      failures++;
      $display("FAIL restart_move: got st=%0d x=%0d y=%0d, want 2 320 239", state, ball_x, ball_y);
    end
  endtask
  task automatic test_reset_mid_play();
    repeat (10) play_tick(1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ball_x, ball_y, score_l, score_r, state, ball_hit, game_over} !== {10'd318, 9'd238, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset: got x=%0d y=%0d sl=%0d sr=%0d st=%0d hit=%0d go=%0d, want 318 238 0 0 0 0 0", ball_x, ball_y, score_l, score_r, state, ball_hit, game_over);
    end
    @(negedge clk) rst = 1'b0;
    tick();
    checks++;
    if ({state, ball_x, ball_y} !== {3'd0, 10'd318, 9'd238}) begin
      failures++;
      $display("FAIL post_reset_idle: got st=%0d x=%0d y=%0d, want 0 318 238", state, ball_x, ball_y);
    end
  endtask
  initial begin
    test_reset();
    test_serve();
    test_right_hit();
    test_bottom_wall();
    test_right_miss();
    test_gameover();
    test_reset_mid_play();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
